// File: rtl/mpu_seq_ctrl.sv
// rtl/mpu_seq_ctrl.sv - A-channel request to MPU sequencer with D-channel response return
//
// Purpose:
//   Pops one request from the A-channel FIFO head, decodes the opcode into MPU
//   control strobes, issues a single-cycle chip select, waits (bounded by
//   TIMEOUT) for MPU completion and returns a D-channel response on the lane
//   of the originating core. Only one MPU operation is in flight at a time.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/opcode/source/
//   address/data, req_deq          FIFO head and its pop pulse (combinational)
//   mpu_cs, mpu_cfg, mpu_we,
//   mpu_free_reserve, mpu_core_id,
//   mpu_addr, mpu_wdata            MPU command (held from ISSUE through RESP)
//   mpu_rdata, mpu_err, mpu_rdy,
//   mpu_bsy                        MPU completion and status
//   d_valid/d_ready                one-hot per-core response handshake
//   d_opcode, d_source, d_data,
//   d_err, d_denied                response payload
//   busy                           sequencer not idle
//   timeout_pulse, drop_pulse      event strobes

module mpu_seq_ctrl #(
   parameter int NUM_CORES  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SRC_WIDTH  = 4,
   parameter int ERR_WIDTH  = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic [2:0]            req_opcode,
   input  logic [SRC_WIDTH-1:0]  req_source,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  req_deq,
   output logic                  mpu_cs,
   output logic                  mpu_cfg,
   output logic                  mpu_we,
   output logic                  mpu_free_reserve,
   output logic [SRC_WIDTH-1:0]  mpu_core_id,
   output logic [ADDR_WIDTH-1:0] mpu_addr,
   output logic [DATA_WIDTH-1:0] mpu_wdata,
   input  logic [DATA_WIDTH-1:0] mpu_rdata,
   input  logic [ERR_WIDTH-1:0]  mpu_err,
   input  logic                  mpu_rdy,
   input  logic                  mpu_bsy,
   output logic [NUM_CORES-1:0]  d_valid,
   input  logic [NUM_CORES-1:0]  d_ready,
   output logic [2:0]            d_opcode,
   output logic [SRC_WIDTH-1:0]  d_source,
   output logic [DATA_WIDTH-1:0] d_data,
   output logic [ERR_WIDTH-1:0]  d_err,
   output logic                  d_denied,
   output logic                  busy,
   output logic                  timeout_pulse,
   output logic                  drop_pulse
);

   // The timer only has to reach TIMEOUT-1 before WAIT is left.
   localparam int             TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                state;
   logic [2:0]            op_q;
   logic [SRC_WIDTH-1:0]  src_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [TW-1:0]         timer_q;

   logic                  deq_go;
   logic                  src_ok;
   logic                  is_read;
   logic                  finish_wait;
   logic [NUM_CORES-1:0]  lane_sel;

   // The pop is combinational so the FIFO head is consumed in the same cycle
   // it is latched. It is qualified by rst_n so that an asserted reset forces
   // it low even though the idle state would otherwise accept the head.
   assign deq_go  = rst_n && (state == S_IDLE) && req_valid && !mpu_bsy;
   assign req_deq = deq_go;

   // MPU command fields come straight from the latched request and therefore
   // stay stable for the whole operation.
   assign mpu_cfg          = op_q[0];
   assign mpu_we           = op_q[1];
   assign mpu_free_reserve = op_q[2];
   assign mpu_core_id      = src_q;
   assign mpu_addr         = addr_q;
   assign mpu_wdata        = wdata_q;

   // Plain read: neither configuration nor write; returns AccessAckData.
   assign is_read = (op_q[1:0] == 2'b00);

   // Sources beyond the number of return lanes have nowhere to go.
   assign src_ok = (32'(src_q) < 32'(NUM_CORES));

   // Completion wins over timeout when both happen in the same cycle.
   assign finish_wait = mpu_rdy || (timer_q == TMO_LAST);

   always_comb begin
      lane_sel = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         lane_sel[i] = (32'(src_q) == 32'(i));
      end
   end

   // d_data / d_err double as the captured MPU read data and error code; they
   // are loaded once on entry to RESP and held until the next operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         op_q          <= '0;
         src_q         <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         timer_q       <= '0;
         mpu_cs        <= 1'b0;
         d_valid       <= '0;
         d_opcode      <= '0;
         d_source      <= '0;
         d_data        <= '0;
         d_err         <= '0;
         d_denied      <= 1'b0;
         busy          <= 1'b0;
         timeout_pulse <= 1'b0;
         drop_pulse    <= 1'b0;
      end else begin
         // Strobes default low so each is a single-cycle pulse.
         mpu_cs        <= 1'b0;
         timeout_pulse <= 1'b0;
         drop_pulse    <= 1'b0;

         case (state)
            S_IDLE: begin
               if (deq_go) begin
                  op_q    <= req_opcode;
                  src_q   <= req_source;
                  addr_q  <= req_address;
                  wdata_q <= req_data;
                  mpu_cs  <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               timer_q <= '0;
               state   <= S_WAIT;
            end

            S_WAIT: begin
               timer_q <= timer_q + 1'b1;
               if (finish_wait) begin
                  d_valid    <= src_ok ? lane_sel : '0;
                  drop_pulse <= !src_ok;
                  d_source   <= src_q;
                  d_opcode   <= {2'b00, is_read};
                  if (mpu_rdy) begin
                     d_data   <= is_read ? mpu_rdata : '0;
                     d_err    <= mpu_err;
                     d_denied <= (mpu_err != '0);
                  end else begin
                     d_data        <= '0;
                     d_err         <= '1;
                     d_denied      <= 1'b1;
                     timeout_pulse <= 1'b1;
                  end
                  state <= S_RESP;
               end
            end

            S_RESP: begin
               // A dropped response leaves after its single RESP cycle; a
               // routed one waits for the ready of its own lane only.
               if (!src_ok || ((d_valid & d_ready) != '0)) begin
                  d_valid <= '0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpu_seq_ctrl.sv
// tb/tb_mpu_seq_ctrl.sv - randomized scoreboard bench for mpu_seq_ctrl
module tb_mpu_seq_ctrl;

   localparam int NC  = 4;
   localparam int TMO = 8;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  src;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic [2:0]  err;
      int          delay;
      bit          rst_here;
   } req_t;

   typedef struct {
      logic [3:0]  src;
      logic [2:0]  dop;
      logic [31:0] data;
      logic [2:0]  err;
      bit          drop;
      bit          tmo;
      int          cyc;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [2:0]  req_opcode;
   logic [3:0]  req_source;
   logic [31:0] req_address;
   logic [31:0] req_data;
   logic        req_deq;
   logic        mpu_cs, mpu_cfg, mpu_we, mpu_free_reserve;
   logic [3:0]  mpu_core_id;
   logic [31:0] mpu_addr, mpu_wdata, mpu_rdata;
   logic [2:0]  mpu_err;
   logic        mpu_rdy, mpu_bsy;
   logic [3:0]  d_valid, d_ready;
   logic [2:0]  d_opcode;
   logic [3:0]  d_source;
   logic [31:0] d_data;
   logic [2:0]  d_err;
   logic        d_denied, busy, timeout_pulse, drop_pulse;

   mpu_seq_ctrl #(.NUM_CORES(NC), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                  .SRC_WIDTH(4), .ERR_WIDTH(3), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_opcode(req_opcode), .req_source(req_source),
      .req_address(req_address), .req_data(req_data), .req_deq(req_deq),
      .mpu_cs(mpu_cs), .mpu_cfg(mpu_cfg), .mpu_we(mpu_we),
      .mpu_free_reserve(mpu_free_reserve), .mpu_core_id(mpu_core_id),
      .mpu_addr(mpu_addr), .mpu_wdata(mpu_wdata), .mpu_rdata(mpu_rdata),
      .mpu_err(mpu_err), .mpu_rdy(mpu_rdy), .mpu_bsy(mpu_bsy),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
      .d_source(d_source), .d_data(d_data), .d_err(d_err), .d_denied(d_denied),
      .busy(busy), .timeout_pulse(timeout_pulse), .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   failures = 0;
   req_t fifo_q[$];
   req_t issued_q[$];
   rsp_t exp_q[$];
   req_t cur;
   bit   in_wait = 0;
   int   idx = 0;
   int   rst_hold = 0;
   int   cs_cnt = 0;
   int   lost = 0;
   int   done_cnt = 0;

   // Values sampled by the monitor on the falling edge, consumed by the driver.
   bit   deq_n = 0;
   bit   cs_n = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic req_t mk(input logic [2:0] op, input logic [3:0] src,
                               input logic [31:0] rdata, input logic [2:0] err,
                               input int delay, input bit rsth);
      req_t r;
      r.op = op; r.src = src; r.addr = $urandom; r.data = $urandom;
      r.rdata = rdata; r.err = err; r.delay = delay; r.rst_here = rsth;
      return r;
   endfunction

   // Reference response derived from the request and how the MPU will answer.
   task automatic push_expect(input req_t r);
      rsp_t e;
      e.src  = r.src;
      e.drop = (r.src >= 4'(NC));
      e.tmo  = (r.delay > TMO - 1);
      e.dop  = (r.op[1:0] == 2'b00) ? 3'd1 : 3'd0;
      e.data = (e.tmo || e.dop == 3'd0) ? 32'd0 : r.rdata;
      e.err  = e.tmo ? 3'b111 : r.err;
      e.cyc  = cyc + 1 + (e.tmo ? TMO - 1 : r.delay);
      exp_q.push_back(e);
   endtask

   task automatic step(input bit gen);
      req_t n;
      @(posedge clk);
      #1;
      if (rst_hold > 0) begin
         rst_hold--;
         if (rst_hold == 0) rst_n = 1'b1;
      end
      if (deq_n && fifo_q.size() != 0) issued_q.push_back(fifo_q.pop_front());
      if (cs_n) begin
         cs_cnt++;
         if (issued_q.size() == 0) begin
            chk("cs_without_deq", 1, 0);
         end else begin
            cur = issued_q.pop_front();
            chk("mpu_cfg", mpu_cfg, cur.op[0]);
            chk("mpu_we", mpu_we, cur.op[1]);
            chk("mpu_free_reserve", mpu_free_reserve, cur.op[2]);
            chk("mpu_core_id", mpu_core_id, cur.src);
            chk("mpu_addr", mpu_addr, cur.addr);
            chk("mpu_wdata", mpu_wdata, cur.data);
            push_expect(cur);
            in_wait = 1;
            idx = 0;
         end
      end
      // Completion strobes outside the wait window are noise the DUT must ignore.
      mpu_rdy   = !in_wait && ($urandom_range(0, 7) == 0);
      mpu_rdata = $urandom;
      mpu_err   = 3'($urandom);
      if (in_wait) begin
         if (cur.rst_here && idx == 2) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mpu_cs", mpu_cs, 0);
            chk("rst_d_valid", d_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_deq", req_deq, 0);
            in_wait = 0;
            void'(exp_q.pop_back());
            lost++;
            rst_hold = 3;
         end else begin
            if (idx == cur.delay) begin
               mpu_rdy = 1'b1; mpu_rdata = cur.rdata; mpu_err = cur.err;
            end
            if (idx == cur.delay || idx == TMO - 1) in_wait = 0;
            idx++;
         end
      end
      if (gen && fifo_q.size() < 3 && $urandom_range(0, 2) == 0) begin
         n = mk(3'($urandom), 4'($urandom_range(0, 5)), $urandom,
                ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom),
                $urandom_range(0, 10), 1'b0);
         fifo_q.push_back(n);
      end
      req_valid = (fifo_q.size() != 0);
      if (fifo_q.size() != 0) begin
         req_opcode = fifo_q[0].op; req_source = fifo_q[0].src;
         req_address = fifo_q[0].addr; req_data = fifo_q[0].data;
      end else begin
         req_opcode = 3'($urandom); req_source = 4'($urandom);
         req_address = $urandom; req_data = $urandom;
      end
      mpu_bsy = ($urandom_range(0, 3) == 0);
      d_ready = 4'($urandom);
   endtask

   // Monitor: pops the scoreboard whenever a response is presented.
   bit          in_resp = 0;
   bit          chk_busy = 0;
   bit          prev_deq = 0;
   logic [45:0] held;
   always @(negedge clk) begin
      rsp_t e;
      if (!rst_n) begin
         in_resp = 0; chk_busy = 0; prev_deq = 0; deq_n = 0; cs_n = 0;
      end else begin
         deq_n = req_deq;
         cs_n  = mpu_cs;
         chk("cs_after_deq", mpu_cs, prev_deq);
         prev_deq = req_deq;
         chk("deq_rule", req_deq, !busy && req_valid && !mpu_bsy);
         if (chk_busy) begin
            chk("busy_after_resp", busy, 0);
            chk_busy = 0;
         end
         if (d_valid != 0 || drop_pulse) begin
            if (!in_resp) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_cycle", cyc, e.cyc);
                  chk("d_valid", d_valid, e.drop ? 4'd0 : 4'(1 << e.src));
                  chk("drop_pulse", drop_pulse, e.drop);
                  chk("timeout_pulse", timeout_pulse, e.tmo);
                  if (!e.drop) begin
                     chk("d_source", d_source, e.src);
                     chk("d_opcode", d_opcode, e.dop);
                     chk("d_data", d_data, e.data);
                     chk("d_err", d_err, e.err);
                     chk("d_denied", d_denied, e.err != 3'd0);
                  end
               end
               held = {d_valid, d_source, d_opcode, d_data, d_err};
               in_resp = 1;
            end else begin
               chk("resp_hold", {d_valid, d_source, d_opcode, d_data, d_err}, held);
               chk("hold_no_pulse", timeout_pulse, 0);
            end
            if (drop_pulse || (d_valid & d_ready) != 0) begin
               in_resp = 0;
               chk_busy = 1;
               done_cnt++;
            end
         end else begin
            chk("resp_vanished", in_resp, 0);
            chk("stray_timeout", timeout_pulse, 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b1; req_opcode = 3'd0; req_source = 4'd0;
      req_address = 32'd0; req_data = 32'd0; mpu_rdata = 32'hFFFF_FFFF;
      mpu_err = 3'd7; mpu_rdy = 1'b1; mpu_bsy = 1'b0; d_ready = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_deq", req_deq, 0);
      chk("reset_mpu_cmd", {mpu_cs, mpu_cfg, mpu_we, mpu_free_reserve}, 0);
      chk("reset_mpu_fields", {mpu_core_id, mpu_addr, mpu_wdata}, 0);
      chk("reset_d_valid", d_valid, 0);
      chk("reset_d_fields", {d_opcode, d_source, d_data, d_err, d_denied}, 0);
      chk("reset_status", {busy, timeout_pulse, drop_pulse}, 0);
      req_valid = 1'b0; mpu_rdy = 1'b0;
      fifo_q.push_back(mk(3'b101, 4'd0, 32'h1234_5678, 3'd0, 1, 1'b0));
      fifo_q.push_back(mk(3'b000, 4'd2, 32'hDEAD_BEEF, 3'd0, 2, 1'b0));
      fifo_q.push_back(mk(3'b010, 4'd1, 32'h0BAD_F00D, 3'd0, 3, 1'b0));
      fifo_q.push_back(mk(3'b001, 4'd3, 32'h5555_AAAA, 3'd0, 20, 1'b0));
      fifo_q.push_back(mk(3'b000, 4'd1, 32'hCAFE_0001, 3'd5, TMO - 1, 1'b0));
      fifo_q.push_back(mk(3'b000, 4'd5, 32'h7777_0000, 3'd0, 1, 1'b0));
      fifo_q.push_back(mk(3'b110, 4'd2, 32'h0, 3'd0, 20, 1'b1));
      fifo_q.push_back(mk(3'b000, 4'd3, 32'hA5A5_5A5A, 3'd0, 0, 1'b0));
      rst_n = 1'b1;
      for (int c = 0; c < 2500; c++) step(1);
      for (int k = 0; k < 500; k++) begin
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !in_wait &&
             rst_hold == 0 && !busy) break;
         step(0);
      end
      step(0);
      step(0);
      chk("drain_fifo", fifo_q.size(), 0);
      chk("drain_scoreboard", exp_q.size(), 0);
      chk("resp_count", done_cnt, cs_cnt - lost);
      chk("reset_case_hit", lost, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mpu_seq_ctrl.md
Name: mpu_seq_ctrl

Overview:
Sequencer between the A-channel request FIFO and the MPU. It pops one arbitrated request, decodes the opcode into MPU control strobes, and issues a single-cycle chip-select. It then waits for MPU completion, with a timeout, and returns a TileLink-style D-channel response to the originating core over a valid/ready handshake. It allows one outstanding MPU operation at a time.

Parameters:
NUM_CORES, 4, number of requesting cores / D-channel return lanes
DATA_WIDTH, 32, MPU data width
ADDR_WIDTH, 32, request address width
SRC_WIDTH, 4, TileLink source-ID width
ERR_WIDTH, 3, MPU error code width; 0 = no error
TIMEOUT, 255, maximum WAIT cycles before a forced error response (min 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  FIFO holds a request (FIFO head valid)
req_opcode  in  3  head opcode
req_source  in  SRC_WIDTH  head source ID
req_address  in  ADDR_WIDTH  head address
req_data  in  DATA_WIDTH  head write data
req_deq  out  1  pop pulse to FIFO
mpu_cs  out  1  MPU chip select
mpu_cfg  out  1  opcode[0]
mpu_we  out  1  opcode[1]
mpu_free_reserve  out  1  opcode[2], 1=reserve
mpu_core_id  out  SRC_WIDTH  latched source
mpu_addr  out  ADDR_WIDTH  latched address
mpu_wdata  out  DATA_WIDTH  latched data
mpu_rdata  in  DATA_WIDTH  MPU read data
mpu_err  in  ERR_WIDTH  MPU error code
mpu_rdy  in  1  MPU completion strobe
mpu_bsy  in  1  MPU busy
d_valid  out  NUM_CORES  one-hot response valid
d_ready  in  NUM_CORES  per-core response ready
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_source  out  SRC_WIDTH  response source
d_data  out  DATA_WIDTH  response data
d_err  out  ERR_WIDTH  response error code
d_denied  out  1  d_err != 0
busy  out  1  state != IDLE
timeout_pulse  out  1  one-cycle pulse when a timeout fires
drop_pulse  out  1  one-cycle pulse when a response is discarded

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. Latched fields, timer, rdata and err registers cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req_valid && !mpu_bsy: latch opcode/source/address/data, assert req_deq combinationally for that cycle, go to ISSUE.
  - Otherwise remain in IDLE; req_deq=0.
- ISSUE:
  - mpu_cs=1 for exactly this one cycle.
  - mpu_cfg/we/free_reserve/core_id/addr/wdata driven from the latched registers. These stay stable from ISSUE through RESP.
  - Clear the timer; go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - On mpu_rdy: capture mpu_rdata and mpu_err, go to RESP.
  - Else if timer == TIMEOUT-1: set err = all ones, data = 0, pulse timeout_pulse, go to RESP.
  - If mpu_rdy arrives in the same cycle as the timeout, mpu_rdy wins and there is no timeout pulse.
- RESP:
  - If latched source >= NUM_CORES: pulse drop_pulse, assert no d_valid, return to IDLE next cycle.
  - Otherwise d_valid[source]=1, all other lanes 0.
  - d_opcode=1 if cfg=0 and we=0 (read), else 0. d_data = captured rdata for reads, 0 otherwise. d_err/d_denied come from captured err.
  - Transfer completes in the cycle where d_valid[source] && d_ready[source]; next state IDLE.
  - While d_ready is low, all D fields are held stable and no new dequeue occurs.
- mpu_rdy outside WAIT is ignored. d_ready on non-selected lanes is ignored.
- Latency:
  - Dequeue at cycle N, mpu_cs at N+1.
  - mpu_rdy at cycle M gives d_valid at M+1.
  - Minimum dequeue-to-d_valid is 3 cycles; minimum d-handshake-to-next-dequeue is 1 cycle.
- Throughput: at most one request in flight; no overlap between RESP and the next ISSUE.
- Reset mid-operation: the in-flight request is lost and no response is generated. After reset the FIFO head is consumed normally.

Test Plan:
1. Reserve: opcode=3'b101, source=0, address with size=4; mpu_rdy 2 cycles after cs, err=0 -> one-cycle mpu_cs with cfg=1, we=0, free_reserve=1; d_valid=4'b0001, d_opcode=0, d_denied=0.
2. Read: opcode=3'b000, source=2; mpu_rdata=32'hDEADBEEF -> d_valid=4'b0100, d_opcode=1, d_data=32'hDEADBEEF, d_source=2.
3. Backpressure: write opcode=3'b010 with d_ready[1] low for 5 cycles and req_valid held high -> d_valid[1] and all D fields stable; req_deq=0 throughout; dequeue occurs 1 cycle after the handshake.
4. Timeout (TIMEOUT=8): mpu_rdy never asserted -> timeout_pulse exactly 8 cycles after entering WAIT; d_err=3'b111, d_denied=1, d_data=0. Separately, mpu_rdy on the timeout cycle -> normal response with no pulse.
5. Bad source: source=5 with NUM_CORES=4 -> no d_valid bit set, drop_pulse=1 for one cycle, busy=0 the next cycle.
6. Reset in WAIT: rst_n low mid-WAIT -> mpu_cs, d_valid, busy, req_deq go to 0 asynchronously. After release, the next request (opcode=3'b000, source=3) completes with d_valid=4'b1000.
